// File: rtl/autocat_pkg.sv
// Shared types and mask/way-count helpers for the autocat waymask applier.
package autocat_pkg;

  localparam int unsigned CACHE_ASSOCIATIVITY = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StIssue,
    StCooldown
  } applier_state_t;

  // Index of the highest set bit plus one; holes below it are ignored.
  function automatic logic [4:0] mask_to_ways(input logic [15:0] mask);
    logic [4:0] ways;
    ways = '0;
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) ways = 5'(i + 1);
    end
    return ways;
  endfunction

  function automatic logic [15:0] ways_to_mask(input logic [4:0] ways);
    logic [16:0] m;
    m = (17'd1 << ways) - 17'd1;
    return m[15:0];
  endfunction

endpackage

// File: rtl/autocat_mask_sanitizer.sv
// Converts an arbitrary waymask into a way count clamped to [MIN_WAYS, 16].
module autocat_mask_sanitizer
  import autocat_pkg::*;
#(
  parameter int unsigned MIN_WAYS = 1
) (
  input  logic [15:0] mask_i,
  output logic [4:0]  ways_o
);

  logic [4:0] raw_ways;

  always_comb begin
    raw_ways = mask_to_ways(mask_i);
    ways_o   = raw_ways;
    if (raw_ways < 5'(MIN_WAYS)) ways_o = 5'(MIN_WAYS);
  end

endmodule

// File: rtl/autocat_waymask_applier.sv
// Applies autocat waymask suggestions one way at a time, with settle and cooldown
// windows, plus a software override that writes the target mask directly.
module autocat_waymask_applier
  import autocat_pkg::*;
#(
  parameter int unsigned CACHE_ASSOCIATIVITY = 16,
  parameter int unsigned MIN_WAYS            = 1,
  parameter int unsigned STABLE_CYCLES       = 64,
  parameter int unsigned COOLDOWN_CYCLES     = 256,
  parameter int unsigned CNT_WIDTH           = 16
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        enable_in,
  input  logic [15:0] suggested_waymask_in,
  input  logic        override_valid_in,
  input  logic [15:0] override_waymask_in,
  output logic        waymask_wr_valid_out,
  output logic [15:0] waymask_wr_data_out,
  input  logic        waymask_wr_ready_in,
  output logic [15:0] waymask_out,
  output logic        busy_out,
  output logic [31:0] update_count_out
);

  if (CACHE_ASSOCIATIVITY != autocat_pkg::CACHE_ASSOCIATIVITY) begin : g_bad_assoc
    $error("autocat_waymask_applier supports only 16 ways");
  end

  applier_state_t       state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [15:0]          latch_q, latch_d;
  logic [15:0]          waymask_q, waymask_d;
  logic [15:0]          wr_data_q, wr_data_d;
  logic [31:0]          upd_q, upd_d;
  logic                 ovr_pend_q, ovr_pend_d;
  logic [15:0]          ovr_mask_q, ovr_mask_d;

  logic [4:0] tgt_ways, ovr_ways, cur_ways, step_ways;
  logic       handshake, ovr_any;

  autocat_mask_sanitizer #(.MIN_WAYS(MIN_WAYS)) u_sugg_sanitizer (
    .mask_i (suggested_waymask_in),
    .ways_o (tgt_ways)
  );

  autocat_mask_sanitizer #(.MIN_WAYS(MIN_WAYS)) u_ovr_sanitizer (
    .mask_i (ovr_mask_q),
    .ways_o (ovr_ways)
  );

  always_comb begin
    cur_ways  = mask_to_ways(waymask_q);
    step_ways = (tgt_ways < cur_ways) ? cur_ways - 5'd1 : cur_ways + 5'd1;
    handshake = (state_q == StIssue) && waymask_wr_ready_in;
    ovr_any   = ovr_pend_q || override_valid_in;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch_d    = latch_q;
    waymask_d  = waymask_q;
    wr_data_d  = wr_data_q;
    upd_d      = upd_q;
    ovr_pend_d = ovr_pend_q;
    ovr_mask_d = ovr_mask_q;

    unique case (state_q)
      StIdle: begin
        if (ovr_pend_q) begin
          wr_data_d  = ways_to_mask(ovr_ways);
          ovr_pend_d = 1'b0;
          state_d    = StIssue;
        end else if (enable_in && (tgt_ways != cur_ways)) begin
          latch_d = suggested_waymask_in;
          cnt_d   = '0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (!enable_in || ovr_pend_q) begin
          state_d = StIdle;
        end else if (suggested_waymask_in != latch_q) begin
          latch_d = suggested_waymask_in;
          cnt_d   = '0;
          if (tgt_ways == cur_ways) state_d = StIdle;
        end else if (cnt_q == CNT_WIDTH'(STABLE_CYCLES - 1)) begin
          wr_data_d = ways_to_mask(step_ways);
          state_d   = StIssue;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIssue: begin
        if (handshake) begin
          waymask_d = wr_data_q;
          upd_d     = (upd_q == '1) ? upd_q : upd_q + 32'd1;
          cnt_d     = '0;
          // A waiting override skips the cooldown of the step it was queued behind.
          state_d   = ovr_any ? StIdle : StCooldown;
        end
      end
      StCooldown: begin
        if (ovr_any || (cnt_q == CNT_WIDTH'(COOLDOWN_CYCLES - 1))) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    // Newest override wins, even over one being consumed this cycle.
    if (override_valid_in) begin
      ovr_pend_d = 1'b1;
      ovr_mask_d = override_waymask_in;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      latch_q    <= 16'hFFFF;
      waymask_q  <= 16'hFFFF;
      wr_data_q  <= 16'hFFFF;
      upd_q      <= '0;
      ovr_pend_q <= 1'b0;
      ovr_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      latch_q    <= latch_d;
      waymask_q  <= waymask_d;
      wr_data_q  <= wr_data_d;
      upd_q      <= upd_d;
      ovr_pend_q <= ovr_pend_d;
      ovr_mask_q <= ovr_mask_d;
    end
  end

  assign waymask_wr_valid_out = (state_q == StIssue);
  assign waymask_wr_data_out  = wr_data_q;
  assign waymask_out          = waymask_q;
  assign busy_out             = (state_q != StIdle);
  assign update_count_out     = upd_q;

endmodule

// File: tb/tb_autocat_waymask_applier.sv
// Directed bench for autocat_waymask_applier with short settle/cooldown windows.
module tb_autocat_waymask_applier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] sugg;
  logic        ovr_valid;
  logic [15:0] ovr_mask;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [15:0] waymask;
  logic        busy;
  logic [31:0] upd_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [15:0] ovr;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  autocat_waymask_applier #(
    .CACHE_ASSOCIATIVITY (16),
    .MIN_WAYS            (2),
    .STABLE_CYCLES       (4),
    .COOLDOWN_CYCLES     (8),
    .CNT_WIDTH           (16)
  ) dut (
    .clk_in               (clk),
    .reset_n_in           (rst_n),
    .enable_in            (enable),
    .suggested_waymask_in (sugg),
    .override_valid_in    (ovr_valid),
    .override_waymask_in  (ovr_mask),
    .waymask_wr_valid_out (wr_valid),
    .waymask_wr_data_out  (wr_data),
    .waymask_wr_ready_in  (wr_ready),
    .waymask_out          (waymask),
    .busy_out             (busy),
    .update_count_out     (upd_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Runs n cycles and reports whether any write request was seen.
  task automatic quiet(input int n, output logic saw);
    saw = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (wr_valid) saw = 1'b1;
    end
  endtask

  task automatic wait_valid(input int n);
    for (int i = 0; i < n && !wr_valid; i++) tick();
  endtask

  initial begin
    logic saw;
    logic held_ok;

    vecs[0] = '{16'h0000, 16'h0003};
    vecs[1] = '{16'h00F0, 16'h00FF};
    vecs[2] = '{16'h00FF, 16'h00FF};
    vecs[3] = '{16'h0004, 16'h0007};
    vecs[4] = '{16'h0001, 16'h0003};
    vecs[5] = '{16'h0FFF, 16'h0FFF};
    vecs[6] = '{16'h8001, 16'hFFFF};

    rst_n = 1'b0; enable = 1'b1; sugg = 16'hFFFF;
    ovr_valid = 1'b0; ovr_mask = '0; wr_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    chk("reset waymask", {16'h0, waymask}, 32'hFFFF);
    chk("reset wr_data", {16'h0, wr_data}, 32'hFFFF);
    chk("reset valid", {31'h0, wr_valid}, 32'h0);
    chk("reset count", upd_count, 32'h0);
    quiet(100, saw);
    chk("idle no write", {31'h0, saw}, 32'h0);
    chk("idle busy", {31'h0, busy}, 32'h0);

    // Glitch: three cycles of 00FF then back.
    sugg = 16'h00FF;
    tick();
    chk("glitch settle busy", {31'h0, busy}, 32'h1);
    tick(); tick();
    sugg = 16'hFFFF;
    tick();
    chk("glitch back idle", {31'h0, busy}, 32'h0);
    quiet(20, saw);
    chk("glitch no write", {31'h0, saw}, 32'h0);
    chk("glitch count", upd_count, 32'h0);

    // Hole mask counts as 16 ways.
    sugg = 16'h8001;
    quiet(20, saw);
    chk("hole no write", {31'h0, saw}, 32'h0);
    chk("hole busy", {31'h0, busy}, 32'h0);

    // Shrink 16 -> 14 in two steps.
    sugg = 16'h3FFF;
    for (int i = 0; i < 4; i++) tick();
    chk("shrink early valid", {31'h0, wr_valid}, 32'h0);
    tick();
    chk("shrink valid1", {31'h0, wr_valid}, 32'h1);
    chk("shrink data1", {16'h0, wr_data}, 32'h7FFF);
    tick();
    exp_cnt = 1;
    chk("shrink mask1", {16'h0, waymask}, 32'h7FFF);
    chk("shrink count1", upd_count, 32'(exp_cnt));
    for (int i = 0; i < 12; i++) tick();
    chk("cooldown no valid", {31'h0, wr_valid}, 32'h0);
    tick();
    chk("shrink valid2", {31'h0, wr_valid}, 32'h1);
    chk("shrink data2", {16'h0, wr_data}, 32'h3FFF);
    tick();
    exp_cnt = 2;
    chk("shrink mask2", {16'h0, waymask}, 32'h3FFF);
    quiet(40, saw);
    chk("shrink done", {31'h0, saw}, 32'h0);
    chk("shrink count2", upd_count, 32'(exp_cnt));

    // Backpressure with a wandering suggestion.
    wr_ready = 1'b0;
    sugg = 16'h0FFF;
    wait_valid(20);
    chk("bp valid", {31'h0, wr_valid}, 32'h1);
    chk("bp data", {16'h0, wr_data}, 32'h1FFF);
    held_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sugg = (i % 2 == 0) ? 16'hFFFF : 16'h00FF;
      tick();
      if (wr_valid !== 1'b1 || wr_data !== 16'h1FFF || waymask !== 16'h3FFF) held_ok = 1'b0;
    end
    chk("bp held", {31'h0, held_ok}, 32'h1);
    wr_ready = 1'b1;
    sugg = 16'h0000;
    tick();
    exp_cnt = 3;
    chk("bp accept", {16'h0, waymask}, 32'h1FFF);

    // Clamp: zero suggestion walks down to MIN_WAYS=2.
    for (int i = 0; i < 400 && waymask !== 16'h0003; i++) tick();
    exp_cnt = 14;
    quiet(40, saw);
    chk("clamp mask", {16'h0, waymask}, 32'h0003);
    chk("clamp stops", {31'h0, saw}, 32'h0);
    chk("clamp count", upd_count, 32'(exp_cnt));

    // Override table with autonomous stepping off.
    enable = 1'b0;
    for (int v = 0; v < 7; v++) begin
      ovr_valid = 1'b1;
      ovr_mask  = vecs[v].ovr;
      tick();
      ovr_valid = 1'b0;
      wait_valid(10);
      chk($sformatf("ovr%0d data", v), {16'h0, wr_data}, {16'h0, vecs[v].exp});
      tick();
      chk($sformatf("ovr%0d mask", v), {16'h0, waymask}, {16'h0, vecs[v].exp});
      exp_cnt++;
    end
    chk("ovr table count", upd_count, 32'(exp_cnt));

    // Override queued behind a stalled step.
    wr_ready = 1'b0;
    enable = 1'b1;
    sugg = 16'h3FFF;
    wait_valid(40);
    chk("ovrq step data", {16'h0, wr_data}, 32'h7FFF);
    ovr_valid = 1'b1;
    ovr_mask  = 16'h000F;
    tick();
    ovr_valid = 1'b0;
    tick(); tick();
    chk("ovrq held valid", {31'h0, wr_valid}, 32'h1);
    chk("ovrq held data", {16'h0, wr_data}, 32'h7FFF);
    wr_ready = 1'b1;
    tick();
    chk("ovrq step mask", {16'h0, waymask}, 32'h7FFF);
    tick();
    chk("ovrq ovr valid", {31'h0, wr_valid}, 32'h1);
    chk("ovrq ovr data", {16'h0, wr_data}, 32'h000F);
    tick();
    exp_cnt += 2;
    chk("ovrq ovr mask", {16'h0, waymask}, 32'h000F);
    chk("ovrq count", upd_count, 32'(exp_cnt));

    // Asynchronous reset in the middle of an ISSUE.
    wr_ready = 1'b0;
    wait_valid(60);
    chk("pre-reset data", {16'h0, wr_data}, 32'h001F);
    rst_n = 1'b0;
    #1;
    chk("arst valid", {31'h0, wr_valid}, 32'h0);
    chk("arst waymask", {16'h0, waymask}, 32'hFFFF);
    chk("arst data", {16'h0, wr_data}, 32'hFFFF);
    chk("arst count", upd_count, 32'h0);
    chk("arst busy", {31'h0, busy}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/autocat_waymask_applier.md
Name: autocat_waymask_applier

Overview:
- Sits directly downstream of the autocat hit-counter/sorter block. Consumes its 16-bit suggested waymask and applies it to the L2 partition waymask register.
- Changes are applied one way per step, only after the suggestion has been stable for a set number of cycles, and with a cooldown between steps so the cache can drain evicted lines.
- A software override path writes the waymask register directly.

Parameters:
- CACHE_ASSOCIATIVITY, 16, number of ways; only 16 is supported.
- MIN_WAYS, 1, lower clamp on the allocated way count (1..16).
- STABLE_CYCLES, 64, consecutive cycles an unchanged suggestion must hold before a step is issued (≥1).
- COOLDOWN_CYCLES, 256, idle cycles after each accepted write (≥1).
- CNT_WIDTH, 16, width of the settle/cooldown counter; must hold max(STABLE_CYCLES, COOLDOWN_CYCLES).

Ports:
- clk_in  input  1  clock.
- reset_n_in  input  1  asynchronous active-low reset.
- enable_in  input  1  autonomous stepping enabled.
- suggested_waymask_in  input  16  waymask from autocat.
- override_valid_in  input  1  single-cycle software override request.
- override_waymask_in  input  16  override waymask, sampled when override_valid_in=1.
- waymask_wr_valid_out  output  1  write request to the waymask register.
- waymask_wr_data_out  output  16  write data; held while valid=1 and ready=0.
- waymask_wr_ready_in  input  1  register accepts the write.
- waymask_out  output  16  currently applied waymask.
- busy_out  output  1  state != IDLE.
- update_count_out  output  32  accepted writes, saturating at 0xFFFFFFFF.

Behaviour:
- Reset (asynchronous, reset_n_in=0):
  - waymask_out=16'hFFFF, cur_ways=16.
  - wr_valid=0, wr_data=16'hFFFF, update_count=0.
  - State IDLE, counter=0, override pending flag cleared.
- Sanitise function (combinational), applied to suggestion and override:
  - ways = (index of highest set bit)+1, or 0 if the mask is zero.
  - Clamp ways to [MIN_WAYS,16].
  - mask(n) = (1<<n)-1, thermometer from bit 0. Holes in the input mask are ignored.
- Only thermometer masks are ever written.
- FSM states: IDLE, SETTLE, ISSUE, COOLDOWN.
- IDLE:
  - A pending override has priority: load wr_data=mask(ovr_ways) and go to ISSUE.
  - Else if enable_in=1 and tgt_ways != cur_ways: latch the suggestion, counter=0, go to SETTLE.
- SETTLE:
  - Each cycle where the input equals the latched value, counter++.
  - If the input differs from the latch: re-latch, counter=0, and return to IDLE if the new tgt_ways==cur_ways.
  - When counter==STABLE_CYCLES-1 with the input still equal: load wr_data=mask(cur_ways±1) (one step toward the target) and go to ISSUE.
  - If enable_in drops: go to IDLE.
  - Latency: difference seen at cycle t → wr_valid asserted at t+1+STABLE_CYCLES.
- ISSUE:
  - wr_valid=1 and wr_data stable until wr_valid & wr_ready.
  - On that handshake cycle: waymask_out<=wr_data, cur_ways updated, update_count++ (saturating), valid drops next cycle, counter=0, go to COOLDOWN.
  - Changes to the suggestion or enable during ISSUE are ignored.
- COOLDOWN:
  - Count to COOLDOWN_CYCLES-1, then go to IDLE.
  - An override arriving during COOLDOWN ends it immediately and goes to IDLE.
- Override:
  - override_valid_in in any state sets a one-entry pending register. A newer override replaces an older one.
  - In ISSUE, the override is held until the current handshake completes, then COOLDOWN is skipped.
  - An override jumps directly to the target with no stepping or settle.
  - It is still issued if its mask equals waymask_out (counted).
- enable_in=0 stops only autonomous steps; waymask_out holds its value.
- ready=1 in the same cycle valid rises: accepted that cycle.
- Reset mid-ISSUE: valid drops asynchronously; waymask_out returns to FFFF.

Decomposition:
- autocat_pkg:
  - CACHE_ASSOCIATIVITY constant.
  - applier_state_t enum {IDLE,SETTLE,ISSUE,COOLDOWN}.
  - Functions mask_to_ways() and ways_to_mask().
- Sub-module autocat_mask_sanitizer: combinational priority encoder plus clamp, instantiated twice (suggestion, override).
- The FSM, counter and handshake stay in the top module.

Test Plan:
- Reset/idle: release reset with suggestion=FFFF, enable=1 → waymask_out=FFFF, no wr_valid for 100 cycles, busy=0.
- Shrink 16→14 (STABLE=4, COOLDOWN=8, ready tied 1): suggestion=3FFF at t → wr_valid at t+5 with data 7FFF.
  - Then after 8 cooldown cycles + IDLE + 5 settle cycles, data 3FFF.
  - update_count=2, final waymask_out=3FFF, no further writes.
- Glitch rejection: suggestion 00FF for 3 cycles, then back to FFFF → no write, returns to IDLE; update_count=0.
- Backpressure: ready=0 for 20 cycles during ISSUE, with the suggestion changing meanwhile → valid held high and data constant.
  - waymask_out updates only on the ready cycle.
- Clamp: MIN_WAYS=2, suggestion=0000 → steps down to 0003 and stops.
  - A hole mask 0x8001 is treated as 16 ways (no change).
- Override: override 000F pulsed during an ISSUE of 7FFF (ready=0) → 7FFF is accepted first, then 000F is issued with no cooldown between.
  - update_count+2; reset asserted mid-ISSUE → outputs return to reset values immediately.
